// File: rtl/qracc_pkg.sv
// rtl/qracc_pkg.sv - shared types and default timing for the SRAM read/write controller
package qracc_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PCH     = 3'd1,
        WL      = 3'd2,
        SENSE   = 3'd3,
        RESP    = 3'd4,
        RECOVER = 3'd5
    } sram_ctrl_state_t;

    localparam int SRAM_NUM_ROWS   = 128;
    localparam int SRAM_NUM_COLS   = 32;
    localparam int SRAM_PCH_CYCLES = 2;
    localparam int SRAM_WL_CYCLES  = 2;

endpackage

// File: rtl/wl_onehot_dec.sv
// rtl/wl_onehot_dec.sv - row address to one-hot wordline, all-zero when disabled
module wl_onehot_dec #(
    parameter int numRows = 128
) (
    input  logic [$clog2(numRows)-1:0] addr_i,
    input  logic                       en_i,
    output logic [numRows-1:0]         wl_o
);

    always_comb begin
        wl_o = '0;
        if (en_i) begin
            wl_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/qracc_sram_rw_ctrl.sv
// rtl/qracc_sram_rw_ctrl.sv - sequences one SRAM request into precharge/wordline/write-or-sense pin timing
module qracc_sram_rw_ctrl
    import qracc_pkg::*;
#(
    parameter int numRows   = SRAM_NUM_ROWS,
    parameter int numCols   = SRAM_NUM_COLS,
    parameter int pchCycles = SRAM_PCH_CYCLES,
    parameter int wlCycles  = SRAM_WL_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rq_valid_i,
    input  logic                       rq_wr_i,
    input  logic [$clog2(numRows)-1:0] addr_i,
    input  logic [numCols-1:0]         wr_data_i,
    input  logic                       mac_busy_i,
    output logic                       rq_ready_o,
    output logic                       rd_valid_o,
    output logic [numCols-1:0]         rd_data_o,
    output logic [numRows-1:0]         WL_o,
    output logic                       PCH_o,
    output logic                       WRITE_o,
    output logic [numCols-1:0]         WR_DATA_o,
    output logic [numCols-1:0]         CSEL_o,
    output logic                       SAEN_o,
    input  logic [numCols-1:0]         SA_OUT_i
);

    localparam int AW      = $clog2(numRows);
    localparam int CNT_MAX = (pchCycles > wlCycles) ? pchCycles : wlCycles;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] PCH_LOAD = CW'(pchCycles - 1);
    localparam logic [CW-1:0] WL_LOAD  = CW'(wlCycles - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    sram_ctrl_state_t   state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [numCols-1:0] data_q, data_d;
    logic [numCols-1:0] rd_data_q, rd_data_d;
    logic               accept;
    logic               wl_en;

    // Gating with rst keeps the port closed for the whole reset pulse, not just after it.
    assign rq_ready_o = (state_q == IDLE) && !mac_busy_i && !rst;
    assign accept     = rq_valid_i && rq_ready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PCH;
                    cnt_d   = PCH_LOAD;
                    wr_d    = rq_wr_i;
                    addr_d  = addr_i;
                    data_d  = wr_data_i;
                end
            end
            PCH: begin
                if (cnt_q == '0) begin
                    state_d = WL;
                    cnt_d   = WL_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WL: begin
                if (cnt_q == '0) begin
                    state_d = wr_q ? RECOVER : SENSE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            SENSE: begin
                rd_data_d = SA_OUT_i;
                state_d   = RESP;
            end
            RESP:    state_d = IDLE;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Wordline stays up through SENSE so the sense amps see a driven bitline pair.
    assign wl_en      = (state_q == WL) || (state_q == SENSE);
    assign PCH_o      = (state_q == PCH);
    assign WRITE_o    = (state_q == WL) && wr_q;
    assign WR_DATA_o  = WRITE_o ? data_q : '0;
    assign CSEL_o     = wl_en ? '1 : '0;
    assign SAEN_o     = (state_q == SENSE);
    assign rd_valid_o = (state_q == RESP);
    assign rd_data_o  = rd_data_q;

    wl_onehot_dec #(
        .numRows(numRows)
    ) u_wl_dec (
        .addr_i(addr_q),
        .en_i  (wl_en),
        .wl_o  (WL_o)
    );

endmodule

// File: tb/tb_qracc_sram_rw_ctrl.sv
// tb/tb_qracc_sram_rw_ctrl.sv - randomized self-checking bench for qracc_sram_rw_ctrl
module tb_qracc_sram_rw_ctrl;

    localparam int ROWS = 128;
    localparam int COLS = 32;
    localparam int AW   = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            rqv_a, rqw_a, mb_a, rdy_a, rdv_a, pch_a, wr_a, saen_a;
    logic [AW-1:0]   addr_a;
    logic [COLS-1:0] wd_a, sa_a, rdd_a, wrd_a, csel_a;
    logic [ROWS-1:0] wl_a;

    logic            rqv_b, rqw_b, mb_b, rdy_b, rdv_b, pch_b, wr_b, saen_b;
    logic [AW-1:0]   addr_b;
    logic [COLS-1:0] wd_b, sa_b, rdd_b, wrd_b, csel_b;
    logic [ROWS-1:0] wl_b;

    int total = 0;
    int bad   = 0;

    logic [COLS-1:0] arr_a [ROWS];
    logic [COLS-1:0] arr_b [ROWS];
    logic [COLS-1:0] exp_mem [ROWS];

    int              ovl = 0;
    int              wr_unstable = 0;
    logic            prev_wr_a = 1'b0, prev_wr_b = 1'b0;
    logic [COLS-1:0] prev_wrd_a = '0, prev_wrd_b = '0;
    logic [ROWS-1:0] prev_wl_a = '0, prev_wl_b = '0;

    qracc_sram_rw_ctrl dut_a (
        .clk(clk), .rst(rst), .rq_valid_i(rqv_a), .rq_wr_i(rqw_a), .addr_i(addr_a),
        .wr_data_i(wd_a), .mac_busy_i(mb_a), .rq_ready_o(rdy_a), .rd_valid_o(rdv_a),
        .rd_data_o(rdd_a), .WL_o(wl_a), .PCH_o(pch_a), .WRITE_o(wr_a), .WR_DATA_o(wrd_a),
        .CSEL_o(csel_a), .SAEN_o(saen_a), .SA_OUT_i(sa_a)
    );

    qracc_sram_rw_ctrl #(.numRows(ROWS), .numCols(COLS), .pchCycles(1), .wlCycles(4)) dut_b (
        .clk(clk), .rst(rst), .rq_valid_i(rqv_b), .rq_wr_i(rqw_b), .addr_i(addr_b),
        .wr_data_i(wd_b), .mac_busy_i(mb_b), .rq_ready_o(rdy_b), .rd_valid_o(rdv_b),
        .rd_data_o(rdd_b), .WL_o(wl_b), .PCH_o(pch_b), .WRITE_o(wr_b), .WR_DATA_o(wrd_b),
        .CSEL_o(csel_b), .SAEN_o(saen_b), .SA_OUT_i(sa_b)
    );

    // Analog array model: a write-driven row stores the driver word; a sensed row is read back.
    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (wr_a && wl_a[r]) arr_a[r] <= wrd_a;
            if (wr_b && wl_b[r]) arr_b[r] <= wrd_b;
        end
    end

    always_comb begin
        sa_a = '0;
        if (saen_a) for (int r = 0; r < ROWS; r++) if (wl_a[r]) sa_a = arr_a[r];
    end

    always_comb begin
        sa_b = '0;
        if (saen_b) for (int r = 0; r < ROWS; r++) if (wl_b[r]) sa_b = arr_b[r];
    end

    always @(negedge clk) begin
        ovl <= ovl + int'(pch_a && (|wl_a)) + int'(pch_b && (|wl_b));
        wr_unstable <= wr_unstable
            + int'(wr_a && prev_wr_a && (wrd_a !== prev_wrd_a || wl_a !== prev_wl_a))
            + int'(wr_b && prev_wr_b && (wrd_b !== prev_wrd_b || wl_b !== prev_wl_b));
        prev_wr_a  <= wr_a;  prev_wrd_a <= wrd_a; prev_wl_a <= wl_a;
        prev_wr_b  <= wr_b;  prev_wrd_b <= wrd_b; prev_wl_b <= wl_b;
    end

    // Issues one request, then records event times as negedge indices after the accept edge.
    task automatic do_op(input bit b, input bit wr, input logic [AW-1:0] ad, input logic [COLS-1:0] d,
                         input int win, output bit acc_ok, output int t_rdy, output int t_rdv,
                         output int n_rdv, output int t_wr, output int n_write, output logic [COLS-1:0] rdata);
        int tmo;
        logic [ROWS-1:0] oh;
        oh = '0;
        oh[ad] = 1'b1;
        acc_ok = 1'b1; t_rdy = -1; t_rdv = -1; n_rdv = 0; t_wr = -1; n_write = 0; rdata = '0;
        @(negedge clk);
        if (b) begin rqv_b = 1'b1; rqw_b = wr; addr_b = ad; wd_b = d; end
        else   begin rqv_a = 1'b1; rqw_a = wr; addr_a = ad; wd_a = d; end
        tmo = 0;
        while (!(b ? rdy_b : rdy_a) && tmo < 100) begin
            @(negedge clk);
            tmo++;
        end
        if (tmo >= 100) acc_ok = 1'b0;
        @(posedge clk);
        #1;
        rqv_a = 1'b0;
        rqv_b = 1'b0;
        for (int k = 1; k <= win; k++) begin
            @(negedge clk);
            if (b ? rdv_b : rdv_a) begin
                n_rdv++;
                if (t_rdv < 0) t_rdv = k;
                rdata = b ? rdd_b : rdd_a;
            end
            if ((b ? rdy_b : rdy_a) && t_rdy < 0) t_rdy = k;
            if (b ? (wr_b && wl_b == oh && wrd_b == d) : (wr_a && wl_a == oh && wrd_a == d)) begin
                n_write++;
                if (t_wr < 0) t_wr = k;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({rdy_a, rdv_a, pch_a, wr_a, saen_a} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b expected 00000", {rdy_a, rdv_a, pch_a, wr_a, saen_a});
        end
        total++;
        if (wl_a !== '0 || csel_a !== '0 || wrd_a !== '0) begin
            bad++;
            $display("FAIL reset_pins: wl=%h csel=%h wrd=%h expected all 0", wl_a, csel_a, wrd_a);
        end
        total++;
        if (rdd_a !== '0) begin
            bad++;
            $display("FAIL reset_rd_data: got %h expected 0", rdd_a);
        end
        rst = 1'b0;
        #1;
        total++;
        if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b%b expected 11", rdy_a, rdy_b);
        end
    endtask

    task automatic test_write();
        bit acc; int t_rdy, t_rdv, n_rdv, t_wr, n_wr; logic [COLS-1:0] rd;
        do_op(0, 1, 7'd5, 32'hA5A5_0F0F, 12, acc, t_rdy, t_rdv, n_rdv, t_wr, n_wr, rd);
        exp_mem[5] = 32'hA5A5_0F0F;
        total++;
        if (!acc || n_wr != 2 || t_wr != 3) begin
            bad++;
            $display("FAIL write_pulse: acc=%0b cycles=%0d first=%0d expected 1/2/3", acc, n_wr, t_wr);
        end
        total++;
        if (t_rdy != 6 || n_rdv != 0) begin
            bad++;
            $display("FAIL write_latency: ready_at=%0d rd_valids=%0d expected 6/0", t_rdy, n_rdv);
        end
    endtask

    task automatic test_read();
        bit acc; int t_rdy, t_rdv, n_rdv, t_wr, n_wr; logic [COLS-1:0] rd;
        do_op(0, 0, 7'd5, '0, 12, acc, t_rdy, t_rdv, n_rdv, t_wr, n_wr, rd);
        total++;
        if (!acc || t_rdv != 6 || n_rdv != 1) begin
            bad++;
            $display("FAIL read_valid: acc=%0b at=%0d pulses=%0d expected 1/6/1", acc, t_rdv, n_rdv);
        end
        total++;
        if (rd !== exp_mem[5] || rdd_a !== exp_mem[5]) begin
            bad++;
            $display("FAIL read_data: got %h held %h expected %h", rd, rdd_a, exp_mem[5]);
        end
        total++;
        if (t_rdy != 7) begin
            bad++;
            $display("FAIL read_ready: got %0d expected 7", t_rdy);
        end
    endtask

    task automatic test_back_to_back();
        bit acc; int t_rdy, t_rdv, n_rdv, t_wr, n_wr; logic [COLS-1:0] rd, d;
        for (int r = 0; r < ROWS; r++) begin
            d = $urandom;
            exp_mem[r] = d;
            do_op(0, 1, AW'(r), d, 6, acc, t_rdy, t_rdv, n_rdv, t_wr, n_wr, rd);
            total++;
            if (!acc || t_rdy != 6 || n_wr != 2) begin
                bad++;
                $display("FAIL b2b_write row %0d: acc=%0b ready_at=%0d wr=%0d expected 1/6/2", r, acc, t_rdy, n_wr);
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            do_op(0, 0, AW'(r), '0, 7, acc, t_rdy, t_rdv, n_rdv, t_wr, n_wr, rd);
            total++;
            if (!acc || t_rdv != 6 || n_rdv != 1 || rd !== exp_mem[r]) begin
                bad++;
                $display("FAIL b2b_read row %0d: got %h at %0d n=%0d expected %h at 6 n=1", r, rd, t_rdv, n_rdv, exp_mem[r]);
            end
        end
        d = $urandom;
        exp_mem[0] = d;
        do_op(0, 1, 7'd0, d, 6, acc, t_rdy, t_rdv, n_rdv, t_wr, n_wr, rd);
        total++;
        if (rdd_a !== exp_mem[ROWS-1]) begin
            bad++;
            $display("FAIL rd_data_hold_over_write: got %h expected %h", rdd_a, exp_mem[ROWS-1]);
        end
    endtask

    task automatic test_mac_busy();
        bit seen; int tmo, t_rdv; logic [COLS-1:0] d, rd;
        d = $urandom;
        @(negedge clk);
        mb_a = 1'b1; rqv_a = 1'b1; rqw_a = 1'b1; addr_a = 7'd9; wd_a = d;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rdy_a || (|wl_a) || pch_a) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL mac_busy_block: activity=%0b expected 0", seen);
        end
        mb_a = 1'b0;
        #1;
        total++;
        if (rdy_a !== 1'b1) begin
            bad++;
            $display("FAIL mac_release_ready: got %b expected 1", rdy_a);
        end
        @(posedge clk);
        #1;
        rqv_a = 1'b0;
        exp_mem[9] = d;
        total++;
        if (pch_a !== 1'b1) begin
            bad++;
            $display("FAIL mac_release_accept: pch=%b expected 1", pch_a);
        end
        tmo = 0;
        while (!rdy_a && tmo < 50) begin @(negedge clk); tmo++; end
        total++;
        if (tmo >= 50) begin
            bad++;
            $display("FAIL mac_release_complete: timeout waiting %0d cycles", tmo);
        end
        @(negedge clk);
        rqv_a = 1'b1; rqw_a = 1'b0; addr_a = 7'd9;
        @(posedge clk);
        #1;
        rqv_a = 1'b0;
        mb_a = 1'b1;
        seen = 1'b0; t_rdv = -1; rd = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rdy_a) seen = 1'b1;
            if (rdv_a && t_rdv < 0) begin t_rdv = k; rd = rdd_a; end
        end
        total++;
        if (t_rdv != 6 || rd !== exp_mem[9] || seen) begin
            bad++;
            $display("FAIL mac_mid_op: rdv_at=%0d data=%h ready_seen=%0b expected 6/%h/0", t_rdv, rd, exp_mem[9], seen);
        end
        mb_a = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        int n_rdv; logic [COLS-1:0] d;
        d = $urandom;
        @(negedge clk);
        rqv_a = 1'b1; rqw_a = 1'b1; addr_a = 7'd20; wd_a = d;
        @(posedge clk);
        #1;
        rqv_a = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (wr_a !== 1'b1 || wl_a[20] !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre: write=%b wl20=%b expected 1/1", wr_a, wl_a[20]);
        end
        rst = 1'b1;
        #1;
        total++;
        if (wr_a !== 1'b0 || wl_a !== '0 || saen_a !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_async: write=%b wl=%h saen=%b expected 0", wr_a, wl_a, saen_a);
        end
        n_rdv = 0;
        repeat (2) begin @(negedge clk); if (rdv_a) n_rdv++; end
        rst = 1'b0;
        repeat (10) begin @(negedge clk); if (rdv_a) n_rdv++; end
        total++;
        if (n_rdv != 0 || rdy_a !== 1'b1 || rdd_a !== '0) begin
            bad++;
            $display("FAIL rst_mid_after: rd_valids=%0d ready=%b rd_data=%h expected 0/1/0", n_rdv, rdy_a, rdd_a);
        end
    endtask

    task automatic test_params();
        bit acc; int t_rdy, t_rdv, n_rdv, t_wr, n_wr; logic [COLS-1:0] rd, d;
        d = $urandom;
        do_op(1, 1, 7'd77, d, 12, acc, t_rdy, t_rdv, n_rdv, t_wr, n_wr, rd);
        total++;
        if (!acc || t_rdy != 7 || n_wr != 4 || t_wr != 2) begin
            bad++;
            $display("FAIL param_write: acc=%0b ready_at=%0d wr=%0d first=%0d expected 1/7/4/2", acc, t_rdy, n_wr, t_wr);
        end
        do_op(1, 0, 7'd77, '0, 12, acc, t_rdy, t_rdv, n_rdv, t_wr, n_wr, rd);
        total++;
        if (!acc || t_rdv != 7 || n_rdv != 1 || rd !== d || t_rdy != 8) begin
            bad++;
            $display("FAIL param_read: at=%0d n=%0d data=%h ready_at=%0d expected 7/1/%h/8", t_rdv, n_rdv, rd, t_rdy, d);
        end
    endtask

    task automatic test_invariants();
        @(negedge clk);
        total++;
        if (ovl != 0) begin
            bad++;
            $display("FAIL pch_wl_overlap: got %0d expected 0", ovl);
        end
        total++;
        if (wr_unstable != 0) begin
            bad++;
            $display("FAIL write_pins_stable: got %0d changes expected 0", wr_unstable);
        end
    endtask

    initial begin
        rst = 1'b1;
        rqv_a = 1'b0; rqw_a = 1'b0; mb_a = 1'b0; addr_a = '0; wd_a = '0;
        rqv_b = 1'b0; rqw_b = 1'b0; mb_b = 1'b0; addr_b = '0; wd_b = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_mac_busy();
        test_params();
        test_reset_mid_write();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
